// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: shared types for the SchoolARM multicycle controller.
// FSM states, mux encodings, condcheck(); UNDEF state exists only with ARM_MC_UNDEF_TRAP_EN.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
`ifdef ARM_MC_UNDEF_TRAP_EN
    , S_UNDEF = 4'd10
`endif
  } statetype;

  localparam statetype RESET_STATE = S_FETCH;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // flags = {N, Z, C, V}
  function automatic logic condcheck(
    input logic [3:0] cond,
    input logic [3:0] flags
  );
    logic n, z, c, v;
    logic ok;
    {n, z, c, v} = flags;
    ok = 1'b0;
    case (cond)
      4'b0000: ok = z;
      4'b0001: ok = !z;
      4'b0010: ok = c;
      4'b0011: ok = !c;
      4'b0100: ok = n;
      4'b0101: ok = !n;
      4'b0110: ok = v;
      4'b0111: ok = !v;
      4'b1000: ok = c && !z;
      4'b1001: ok = !c || z;
      4'b1010: ok = (n == v);
      4'b1011: ok = (n != v);
      4'b1100: ok = !z && (n == v);
      4'b1101: ok = z || (n != v);
      4'b1110: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/arm_mc_fsm.sv
// arm_mc_fsm: state register, next-state logic and raw per-state controls.
// in: clk, reset, op, funct bits, rd_pc; out: state, raw enables/selects (ARM_MC_UNDEF_TRAP_EN adds UNDEF).
module arm_mc_fsm
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic       funct5,
  input  logic       funct4,
  input  logic       funct0,
  input  logic       rd_pc,
  output statetype   state,
  output logic       pc_write,
  output logic       pc_cond,
  output logic       ir_write,
  output logic       reg_cond,
  output logic       mem_cond,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] reg_src,
  output logic       wd3_src,
  output logic       alu_dec,
  output logic       flag_en
);

  statetype state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    pc_cond    = 1'b0;
    ir_write   = 1'b0;
    reg_cond   = 1'b0;
    mem_cond   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RD2;
    result_src = RES_ALUOUT;
    reg_src    = 2'b00;
    wd3_src    = 1'b0;
    alu_dec    = 1'b0;
    flag_en    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        pc_write   = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        reg_src    = {op == 2'b01 && !funct0,
                      op == 2'b10};
        unique case (1'b1)
          op == 2'b01:            state_d = S_MEMADR;
          op == 2'b00 && !funct5: state_d = S_EXECR;
          op == 2'b00 && funct5:  state_d = S_EXECI;
          op == 2'b10 && funct5:  state_d = S_BRANCH;
`ifdef ARM_MC_UNDEF_TRAP_EN
          default:                state_d = S_UNDEF;
`else
          default:                state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_b = SRCB_IMM;
        state_d   = funct0 ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_cond   = 1'b1;
      end
      S_MEMWR: begin
        adr_src  = 1'b1;
        mem_cond = 1'b1;
      end
      S_EXECR: begin
        alu_dec = 1'b1;
        flag_en = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_b = SRCB_IMM;
        alu_dec   = 1'b1;
        flag_en   = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        // a write to R15 becomes a PC redirect
        reg_cond = !rd_pc;
        pc_cond  = rd_pc;
      end
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURES;
        pc_cond    = 1'b1;
        wd3_src    = funct4;
        reg_cond   = funct4;
      end
`ifdef ARM_MC_UNDEF_TRAP_EN
      S_UNDEF: state_d = S_UNDEF;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/arm_mc_controller.sv
// arm_mc_controller: SchoolARM multicycle control unit (ALU decode, NZCV, cond gating).
// in: clk, reset, Instr, ALUFlags; out: datapath enables/selects, Flags, State. Option: ARM_MC_UNDEF_TRAP_EN.
module arm_mc_controller
  import arm_mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic        WD3Src,
  output logic [3:0]  Flags,
  output logic [3:0]  State
);

  statetype   state;
  logic       pc_write, pc_cond, ir_write;
  logic       reg_cond, mem_cond, alu_dec, flag_en;
  logic [1:0] alu_ctl;
  logic       upd_nz, upd_cv;
  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;
  logic       unused_bits;

  assign unused_bits = ^{Instr[19:16], Instr[11:0]};

  arm_mc_fsm u_fsm (
    .clk        (clk),
    .reset      (reset),
    .op         (Instr[27:26]),
    .funct5     (Instr[25]),
    .funct4     (Instr[24]),
    .funct0     (Instr[20]),
    .rd_pc      (Instr[15:12] == 4'hF),
    .state      (state),
    .pc_write   (pc_write),
    .pc_cond    (pc_cond),
    .ir_write   (ir_write),
    .reg_cond   (reg_cond),
    .mem_cond   (mem_cond),
    .adr_src    (AdrSrc),
    .alu_src_a  (ALUSrcA),
    .alu_src_b  (ALUSrcB),
    .result_src (ResultSrc),
    .reg_src    (RegSrc),
    .wd3_src    (WD3Src),
    .alu_dec    (alu_dec),
    .flag_en    (flag_en)
  );

  // MOV drives ADD; the datapath supplies the zero operand
  always_comb begin
    alu_ctl = ALU_ADD;
    upd_nz  = 1'b0;
    upd_cv  = 1'b0;
    unique case (Instr[24:21])
      4'b0100: begin alu_ctl = ALU_ADD; upd_nz = 1'b1; upd_cv = 1'b1; end
      4'b0010: begin alu_ctl = ALU_SUB; upd_nz = 1'b1; upd_cv = 1'b1; end
      4'b0000: begin alu_ctl = ALU_AND; upd_nz = 1'b1; end
      4'b1100: begin alu_ctl = ALU_ORR; upd_nz = 1'b1; end
      4'b1101: begin alu_ctl = ALU_ADD; upd_nz = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    flags_d  = flags_q;
    condex_d = condex_q;
    if (state == S_DECODE)
      condex_d = condcheck(Instr[31:28], flags_q);
    if (flag_en && condex_q && Instr[20]) begin
      if (upd_nz) flags_d[3:2] = ALUFlags[3:2];
      if (upd_cv) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  // enables forced low for the whole reset assertion
  assign PCWrite    = !reset && (pc_write || (pc_cond && condex_q));
  assign IRWrite    = !reset && ir_write;
  assign RegWrite   = !reset && reg_cond && condex_q;
  assign MemWrite   = !reset && mem_cond && condex_q;
  assign ALUControl = alu_dec ? alu_ctl : ALU_ADD;
  assign ImmSrc     = Instr[27:26];
  assign Flags      = flags_q;
  assign State      = state;

endmodule

// File: tb/tb_arm_mc_controller.sv
// tb_arm_mc_controller: directed plus random instruction stream vs. an
// instruction-level model of the multicycle controller.
module tb_arm_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Instr = 32'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic        ALUSrcA, WD3Src;
  logic [3:0]  Flags, State;

  int checks = 0;
  int errors = 0;
  logic [3:0] mflags = 4'h0;

  int srcb_t [11] = '{2, 2, 1, 0, 0, 0, 0, 1, 0, 1, 0};
  int res_t  [11] = '{2, 2, 0, 0, 1, 0, 0, 0, 0, 2, 0};

  arm_mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .WD3Src     (WD3Src),
    .Flags      (Flags),
    .State      (State)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ARM rule: cond[3:1] picks a base test, cond[0] inverts it; 111x is AL/never
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, b;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cf;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cf & !z;
      3'd5: b = (n == v);
      3'd6: b = !z & (n == v);
      default: return !c[0];
    endcase
    return b ^ c[0];
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(State), 32'd0);
    chk({tag, "_pcw"}, 32'(PCWrite), 32'd0);
    chk({tag, "_irw"}, 32'(IRWrite), 32'd0);
    chk({tag, "_rw"}, 32'(RegWrite), 32'd0);
    chk({tag, "_mw"}, 32'(MemWrite), 32'd0);
    chk({tag, "_flags"}, 32'(Flags), 32'd0);
  endtask

  // called at posedge+1 with the FSM in FETCH; returns at posedge+1
  task automatic run_instr(input logic [31:0] ins, input int stop_k,
                           input int fl);
    int seq[$];
    logic [1:0] op;
    logic [5:0] f;
    logic pass, rd15, is_undef;
    logic [1:0] am;
    int kind, st, mw_cnt;
    op = ins[27:26];
    f = ins[25:20];
    rd15 = (ins[15:12] == 4'hF);
    is_undef = 1'b0;
    if (op == 2'b01) seq = f[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
    else if (op == 2'b00) seq = f[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
    else if (op == 2'b10 && f[5]) seq = '{0, 1, 9};
    else begin seq = '{0, 1}; is_undef = 1'b1; end
    pass = cond_ok(ins[31:28], mflags);
    case (f[4:1])
      4'b0100: begin am = 2'd0; kind = 2; end
      4'b0010: begin am = 2'd1; kind = 2; end
      4'b0000: begin am = 2'd2; kind = 1; end
      4'b1100: begin am = 2'd3; kind = 1; end
      4'b1101: begin am = 2'd0; kind = 1; end
      default: begin am = 2'd0; kind = 0; end
    endcase
    Instr = ins;
    mw_cnt = 0;
    foreach (seq[k]) begin
      st = seq[k];
      ALUFlags = (fl >= 0) ? 4'(fl) : 4'($urandom);
      @(negedge clk);
      chk("state", 32'(State), 32'(st));
      chk("pcwrite", 32'(PCWrite),
          32'((st == 0) || (st == 9 && pass) || (st == 8 && rd15 && pass)));
      chk("irwrite", 32'(IRWrite), 32'(st == 0));
      chk("regwrite", 32'(RegWrite),
          32'(pass && (st == 4 || (st == 8 && !rd15) || (st == 9 && f[4]))));
      chk("memwrite", 32'(MemWrite), 32'(pass && st == 5));
      chk("adrsrc", 32'(AdrSrc), 32'(st == 3 || st == 5));
      chk("alusrca", 32'(ALUSrcA), 32'(st <= 1));
      chk("alusrcb", 32'(ALUSrcB), 32'(srcb_t[st]));
      chk("resultsrc", 32'(ResultSrc), 32'(res_t[st]));
      chk("regsrc", 32'(RegSrc),
          32'((st == 1) ? {op == 2'b01 && !f[0], op == 2'b10} : 2'b00));
      chk("immsrc", 32'(ImmSrc), 32'(op));
      chk("alucontrol", 32'(ALUControl), 32'((st == 6 || st == 7) ? am : 2'd0));
      chk("wd3src", 32'(WD3Src), 32'(st == 9 && f[4]));
      chk("flags", 32'(Flags), 32'(mflags));
      if (MemWrite) mw_cnt++;
      if (k == stop_k) begin
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1 reset = 1'b0;
        mflags = 4'h0;
        return;
      end
      @(posedge clk);
      if ((st == 6 || st == 7) && pass && f[0] && kind > 0) begin
        mflags[3:2] = ALUFlags[3:2];
        if (kind == 2) mflags[1:0] = ALUFlags[1:0];
      end
      #1;
    end
    if (op == 2'b01 && !f[0])
      chk("str_pulse", 32'(mw_cnt), pass ? 32'd1 : 32'd0);
`ifdef ARM_MC_UNDEF_TRAP_EN
    if (is_undef) begin
      repeat (20) begin
        ALUFlags = 4'($urandom);
        @(negedge clk);
        chk("undef_state", 32'(State), 32'd10);
        chk("undef_en", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        chk("undef_flags", 32'(Flags), 32'(mflags));
        @(posedge clk);
        #1;
      end
      reset = 1'b1;
      #1;
      check_reset_outputs("undef_reset");
      @(posedge clk);
      #1 reset = 1'b0;
      mflags = 4'h0;
    end
`endif
  endtask

  initial begin
    logic [31:0] ins;
    int cls;
    #1 reset = 1'b1;
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    run_instr(32'hE0821003, -1, -1);
    run_instr(32'hE0821003, 2, -1);
    run_instr(32'hE0500000, -1, 6);
    chk("subs_flags", 32'(Flags), 32'h6);
    run_instr(32'h00821003, -1, -1);
    run_instr(32'h10821003, -1, -1);
    chk("addne_flags", 32'(Flags), 32'h6);
    run_instr(32'hE5912004, -1, -1);
    run_instr(32'hE5812004, -1, -1);
    run_instr(32'hEB000002, -1, -1);
    run_instr(32'h1A000002, -1, -1);
    run_instr(32'hE1A0F001, -1, -1);
    run_instr(32'hF0821003, -1, -1);
    run_instr(32'h08000000, -1, -1);
    run_instr(32'h0C000000, -1, -1);

    for (int i = 0; i < 120; i++) begin
      ins = $urandom;
      cls = $urandom_range(0, 5);
`ifdef ARM_MC_UNDEF_TRAP_EN
      if (cls == 4) cls = 1;
`endif
      case (cls)
        0: ins[27:26] = 2'b01;
        1: ins[27:26] = 2'b00;
        2: begin ins[27:26] = 2'b10; ins[25] = 1'b1; end
        3: begin
          ins[27:26] = 2'b00;
          ins[20] = 1'b1;
          case ($urandom_range(0, 4))
            0: ins[24:21] = 4'b0100;
            1: ins[24:21] = 4'b0010;
            2: ins[24:21] = 4'b0000;
            3: ins[24:21] = 4'b1100;
            default: ins[24:21] = 4'b1101;
          endcase
        end
        4: begin
          if ($urandom_range(0, 1) == 0) ins[27:26] = 2'b11;
          else begin ins[27:26] = 2'b10; ins[25] = 1'b0; end
        end
        default: begin ins[31:28] = 4'hE; ins[27:26] = 2'b00; end
      endcase
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
      run_instr(ins, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arm_mc_controller.md
Name: arm_mc_controller

Overview:
Multicycle control unit for the SchoolARM core. It sequences one shared ALU, one unified instruction/data memory port and the register file over 3-5 cycles per instruction.
- Holds the NZCV flag register and evaluates condition codes.
- Decodes the same instruction subset as the single-cycle core: ADD/SUB/AND/ORR/MOV (register and immediate forms), LDR, STR, B and BL.
- Sits between the instruction register and the multicycle datapath's muxes and enables.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset (fixed; listed for the bench only).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- Instr  in  32  instruction register contents (Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12])
- ALUFlags  in  4  NZCV from ALU, combinational in the current cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUResult register
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  0=RD1 register, 1=PC
- ALUSrcB  out  2  00=RD2 register, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  extender mode (Instr[27:26] passthrough)
- RegSrc  out  2  register read-address selects
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- WD3Src  out  1  link write: A3=R14, WD3=PC
- Flags  out  4  registered NZCV (observability)
- State  out  4  current FSM state encoding

Behaviour:
- Reset: asynchronous, active-high. While asserted: State=S_FETCH, Flags=0000, CondExReg=0, and every enable (PCWrite, MemWrite, IRWrite, RegWrite) is 0. After reset releases, the first cycle is FETCH.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, UNDEF=10
- FETCH:
  - Outputs: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, PCWrite=1 (unconditional NextPC).
  - Next state: DECODE.
- DECODE:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; no writes. RegSrc is decoded from Instr: [0]=1 for branch, [1]=1 for STR.
  - CondExReg <= condcheck(Cond, Flags). Condition codes: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL; 1111 evaluates false.
  - Next state: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECR; Op=00 with Funct[5]=1 -> EXECI; Op=10 with Funct[5]=1 -> BRANCH; otherwise FETCH (no-op).
- MEMADR:
  - Outputs: ALUSrcA=0, ALUSrcB=01, ALUControl=00.
  - Next state: Funct[0]=1 -> MEMRD, else MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Next state: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondExReg. Next state: FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondExReg. Next state: FETCH.
- EXECR / EXECI:
  - ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 (EXECI).
  - ALUControl from Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1101 MOV (drives ADD; the datapath supplies a zero operand). Any other value -> ADD with no flag update.
  - Flags update at the clock edge ending the state, and only if CondExReg and Funct[0]=1. N,Z always update; C,V update only for ADD/SUB.
  - Next state: ALUWB.
- ALUWB:
  - ResultSrc=00, RegWrite=CondExReg.
  - If Rd=1111: RegWrite=0 and PCWrite=CondExReg, i.e. a write to R15 redirects the PC.
  - Next state: FETCH.
- BRANCH:
  - ALUSrcA=0, ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite=CondExReg.
  - BL (Funct[4]=1): WD3Src=1 and RegWrite=CondExReg in this same cycle. The PC is sampled before the update.
  - Next state: FETCH.
- Flags never change outside EXECR/EXECI.
- Condition evaluation always uses the pre-instruction flags, because CondExReg is latched in DECODE.
- Any output not listed for a state is 0.
- CPI: LDR 5, STR 4, data-processing 4, branch 3, undefined or failed-decode 2.

Optional Feature:
- Macro: ARM_MC_UNDEF_TRAP_EN.
- Defined:
  - In DECODE, Op=11, or Op=10 with Funct[5]=0, moves to UNDEF instead of FETCH.
  - UNDEF holds all enables at 0 and stays there until reset. State output reads 10.
- Undefined: these encodings return to FETCH as a 2-cycle no-op, and the UNDEF state is absent.

Decomposition:
- Package arm_mc_pkg holds:
  - typedef enum logic [3:0] statetype for the FSM states;
  - the ALUControl and ResultSrc/ALUSrcB encoding localparams;
  - a function condcheck(cond, flags).
- Sub-module arm_mc_fsm: state register plus next-state and per-state raw controls.
- arm_mc_controller contains the ALU decoder, flag register, CondExReg and write gating.

Test Plan:
- Reset then run ADD R1,R2,R3 (E0821003): states 0,1,6,8,0. In ALUWB, RegWrite=1 and ALUControl=00. Assert reset mid-EXECR -> State=0 and enables 0 in the same cycle.
- SUBS R0,R0,R0 (E0500000): Flags become 0110 after EXECR. Then ADDEQ (0...): RegWrite=1. Then ADDNE (1...): 4 cycles with RegWrite=0 and Flags unchanged.
- LDR (E5912004) takes 5 cycles with AdrSrc=1 in MEMRD and RegWrite in MEMWB. STR (E5812004) takes 4 cycles with a MemWrite pulse of exactly 1 cycle.
- BL (EB000002) takes 3 cycles. In BRANCH: PCWrite=1, RegWrite=1, WD3Src=1. BNE with Z=1: PCWrite=0 in BRANCH.
- MOV PC,R1 (E1A0F001): ALUWB gives PCWrite=1, RegWrite=0. Instruction F0821003 (cond 1111) executes with no writes.
- Instruction 0C000000 (Op=11): without the macro, returns to FETCH after 2 cycles. With ARM_MC_UNDEF_TRAP_EN, State=10 persists for 20 or more cycles until reset.
